// File: rtl/pc_fetch_stage.sv
// Program counter, RUN/HALT fetch FSM and IF/ID pipeline register for the MIPS datapath.
// Instruction memory is read combinationally at pc; the fetched word appears in IF/ID one clock later.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;
    count_d    = count_q;

    if (redirect_en) begin
      // Redirect overrides stall and always leaves exactly one bubble behind it.
      pc_d       = {redirect_target[31:2], 2'b00};
      if_instr_d = 32'h0;
      if_valid_d = 1'b0;
      state_d    = ST_RUN;
      if (redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (state_q == ST_HALT) begin
      if (!stall) begin
        if_instr_d = 32'h0;
        if_valid_d = 1'b0;
      end
    end else begin
      if (flush) begin
        if_instr_d = 32'h0;
        if_valid_d = 1'b0;
      end else if (!stall) begin
        if_pc_d    = pc_q;
        if_pc4_d   = pc_plus4;
        if_instr_d = imem_rdata;
        if_valid_d = 1'b1;
        count_d    = count_q + 32'd1;
        if (imem_rdata == HALT_INSTR) begin
          state_d = ST_HALT;
        end
      end
      if (!stall) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_pc4_q   <= 32'h0;
      if_instr_q <= 32'h0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_pc        = if_pc_q;
  assign if_pc_plus4  = if_pc4_q;
  assign if_instr     = if_instr_q;
  assign if_valid     = if_valid_q;
  assign halted       = (state_q == ST_HALT);
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: a spec-level model pushes the expected post-edge
// state per driven cycle; a monitor pops and compares, and each scenario adds fixed-value checks.
module tb_pc_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int vectors    = 0;
  int miscompares = 0;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000), .HALT_INSTR(32'h0000_000C)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr), .if_valid(if_valid),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic        halt;
    logic        mis;
    logic [31:0] cnt;
  } snap_t;

  snap_t sb[$];
  snap_t obs;
  assign obs = '{addr: imem_addr, pc: if_pc, pc4: if_pc_plus4, instr: if_instr,
                 valid: if_valid, halt: halted, mis: misalign_err, cnt: fetch_count};

  // Reference model state, written from the behavioural description.
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_cnt;
  logic        m_valid, m_halt, m_mis;

  task automatic model_step(input logic r, input logic s, input logic f, input logic rd,
                            input logic [31:0] t, input logic [31:0] d);
    if (r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
      m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    end else if (rd) begin
      if (t[1:0] != 2'b00) m_mis = 1'b1;
      m_pc = t & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_instr = 32'h0; m_halt = 1'b0;
    end else if (m_halt) begin
      if (!s) begin m_valid = 1'b0; m_instr = 32'h0; end
    end else begin
      if (f) begin
        m_valid = 1'b0; m_instr = 32'h0;
      end else if (!s) begin
        m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_instr = d; m_valid = 1'b1;
        m_cnt = m_cnt + 32'd1;
        if (d == 32'h0000_000C) m_halt = 1'b1;
      end
      if (!s) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic f, input logic rd,
                     input logic [31:0] t, input logic [31:0] d);
    reset = r; stall = s; flush = f; redirect_en = rd; redirect_target = t; imem_rdata = d;
    model_step(r, s, f, rd, t, d);
    sb.push_back('{addr: m_pc, pc: m_ifpc, pc4: m_ifpc4, instr: m_instr,
                   valid: m_valid, halt: m_halt, mis: m_mis, cnt: m_cnt});
    @(posedge clk);
    #2;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      snap_t ex;
      ex = sb.pop_front();
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("FAIL scoreboard t=%0t got %h want %h", $time, obs, ex);
      end
    end
  end

  task automatic test_reset;
    cyc(1, 0, 0, 0, 32'h0, 32'h0);
    cyc(1, 1, 1, 1, 32'h0000_0123, 32'h0000_000C);
    vectors++;
    if ({imem_addr, if_pc, if_pc_plus4, if_instr, fetch_count} !== 160'h0) begin
      miscompares++;
      $display("FAIL reset_words got %h/%h/%h/%h/%h want all 0",
               imem_addr, if_pc, if_pc_plus4, if_instr, fetch_count);
    end
    vectors++;
    if ({if_valid, halted, misalign_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags got %b%b%b want 000", if_valid, halted, misalign_err);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 32'h0, 32'h2008_0001);
      vectors++;
      if (if_pc !== 32'(i * 4) || if_valid !== 1'b1 || if_instr !== 32'h2008_0001) begin
        miscompares++;
        $display("FAIL seq_fetch%0d got pc=%h v=%b i=%h want pc=%h v=1 i=20080001",
                 i, if_pc, if_valid, if_instr, 32'(i * 4));
      end
    end
    vectors++;
    if (fetch_count !== 32'd3 || imem_addr !== 32'd12) begin
      miscompares++;
      $display("FAIL seq_count got cnt=%0d addr=%h want cnt=3 addr=c", fetch_count, imem_addr);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 32'h0, 32'hDEAD_BEEF);
      vectors++;
      if (imem_addr !== 32'd12 || if_pc !== 32'd8 || if_instr !== 32'h2008_0001 ||
          fetch_count !== 32'd3) begin
        miscompares++;
        $display("FAIL stall_hold got addr=%h pc=%h i=%h cnt=%0d want c/8/20080001/3",
                 imem_addr, if_pc, if_instr, fetch_count);
      end
    end
    cyc(0, 0, 0, 0, 32'h0, 32'h1111_2222);
    vectors++;
    if (if_pc !== 32'd12 || if_instr !== 32'h1111_2222 || imem_addr !== 32'd16) begin
      miscompares++;
      $display("FAIL stall_resume got pc=%h i=%h addr=%h want c/11112222/10",
               if_pc, if_instr, imem_addr);
    end
  endtask

  task automatic test_flush;
    cyc(0, 0, 1, 0, 32'h0, 32'h3333_4444);
    vectors++;
    if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'd12 || imem_addr !== 32'd20 ||
        fetch_count !== 32'd4) begin
      miscompares++;
      $display("FAIL flush_bubble got v=%b i=%h pc=%h addr=%h cnt=%0d want 0/0/c/14/4",
               if_valid, if_instr, if_pc, imem_addr, fetch_count);
    end
    cyc(0, 1, 1, 0, 32'h0, 32'h3333_4444);
    vectors++;
    if (if_valid !== 1'b0 || imem_addr !== 32'd20) begin
      miscompares++;
      $display("FAIL flush_stall got v=%b addr=%h want 0/14", if_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_stall;
    cyc(0, 1, 0, 1, 32'h0000_0040, 32'h5555_6666);
    vectors++;
    if (imem_addr !== 32'h40 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_bubble got addr=%h v=%b want 40/0", imem_addr, if_valid);
    end
    cyc(0, 0, 0, 0, 32'h0, 32'h5555_6666);
    vectors++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1 || if_pc_plus4 !== 32'h44) begin
      miscompares++;
      $display("FAIL redir_first got pc=%h v=%b pc4=%h want 40/1/44", if_pc, if_valid, if_pc_plus4);
    end
  endtask

  task automatic test_misalign;
    cyc(0, 0, 0, 1, 32'h0000_0042, 32'h0);
    vectors++;
    if (imem_addr !== 32'h40 || misalign_err !== 1'b1) begin
      miscompares++;
      $display("FAIL misalign_set got addr=%h err=%b want 40/1", imem_addr, misalign_err);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'(i % 3 == 0), 1'(i % 4 == 1), 1'(i == 5), 32'h0000_0100, 32'h7000_0000 + 32'(i));
      vectors++;
      if (misalign_err !== 1'b1) begin
        miscompares++;
        $display("FAIL misalign_sticky%0d got %b want 1", i, misalign_err);
      end
    end
    cyc(1, 0, 0, 0, 32'h0, 32'h0);
    vectors++;
    if (misalign_err !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_clear got %b want 0", misalign_err);
    end
  endtask

  task automatic test_halt;
    cyc(0, 0, 0, 1, 32'h0000_0010, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0000_000C);
    vectors++;
    if (if_instr !== 32'hC || halted !== 1'b1 || if_valid !== 1'b1 || if_pc !== 32'h10) begin
      miscompares++;
      $display("FAIL halt_enter got i=%h h=%b v=%b pc=%h want c/1/1/10",
               if_instr, halted, if_valid, if_pc);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 32'h0, 32'h2008_0001);
      vectors++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h14 || halted !== 1'b1 || fetch_count !== 32'd1) begin
        miscompares++;
        $display("FAIL halt_frozen%0d got v=%b addr=%h h=%b cnt=%0d want 0/14/1/1",
                 i, if_valid, imem_addr, halted, fetch_count);
      end
    end
    cyc(0, 0, 0, 1, 32'h0, 32'h0);
    vectors++;
    if (halted !== 1'b0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL halt_exit got h=%b addr=%h want 0/0", halted, imem_addr);
    end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0ABC_0000);
    vectors++;
    if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap got addr=%h pc=%h pc4=%h want 0/fffffffc/0", imem_addr, if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_reset_priority;
    cyc(0, 0, 0, 0, 32'h0, 32'h0000_000C);
    cyc(0, 1, 0, 1, 32'h0000_0203, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 32'h0000_000C);
    cyc(1, 1, 1, 1, 32'h0000_0301, 32'h0000_000C);
    vectors++;
    if ({imem_addr, fetch_count, halted, misalign_err, if_valid} !== 67'h0) begin
      miscompares++;
      $display("FAIL reset_prio got addr=%h cnt=%0d h=%b err=%b v=%b want all 0",
               imem_addr, fetch_count, halted, misalign_err, if_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 9) == 0) ? 32'h0000_000C : $urandom;
      cyc(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 7) == 0), $urandom, d);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0;
    redirect_target = 32'h0; imem_rdata = 32'h0;
    m_pc = 0; m_ifpc = 0; m_ifpc4 = 0; m_instr = 0; m_cnt = 0;
    m_valid = 0; m_halt = 0; m_mis = 0;
    #2;
    test_reset;
    test_sequential;
    test_stall;
    test_flush;
    test_redirect_stall;
    test_misalign;
    test_halt;
    test_wrap;
    test_reset_priority;
    test_random;
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
